// File: rtl/fpga_top_mul_arbiter_if.sv
// Request/response bundle between NREQ requesters, the shared-multiplier arbiter and the product consumer.
// The master side drives operands and rsp_ready; the slave side (arbiter) drives grants and products.
interface fpga_top_mul_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*10-1:0] req_a;
    logic [NREQ*9-1:0]  req_b;
    logic [NREQ-1:0]    req_ready;
    logic               rsp_valid;
    logic [IDW-1:0]     rsp_id;
    logic [15:0]        rsp_p;
    logic               rsp_ready;
    logic [31:0]        mul_count;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_p, mul_count
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_p, mul_count
    );
endinterface

// File: rtl/fpga_top_mul_arbiter.sv
// Round-robin arbiter sharing one 10x9 multiplier: operand stage A -> multiplier -> product stage B, one product/cycle, 2-deep buffering under backpressure.
// Build option FPGA_TOP_MUL_ARB_SAT_EN: saturate the product to 16'hFFFF instead of wrapping modulo 2^16.
module fpga_top_mul_mul_10ns_9ns_16_1_1 (
    input  logic [9:0]  i_din0,
    input  logic [8:0]  i_din1,
    output logic [15:0] o_dout
);
    logic [15:0] w_a16;
    logic [15:0] w_b16;

    assign w_a16  = {6'b0, i_din0};
    assign w_b16  = {7'b0, i_din1};
    assign o_dout = w_a16 * w_b16;
endmodule

module fpga_top_mul_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    fpga_top_mul_arbiter_if.slave bus
);
    logic            r_op_vld;
    logic [9:0]      r_op_a;
    logic [8:0]      r_op_b;
    logic [IDW-1:0]  r_op_id;
    logic            r_rsp_valid;
    logic [15:0]     r_rsp_p;
    logic [IDW-1:0]  r_rsp_id;
    logic [IDW-1:0]  r_rr_ptr;
    logic [31:0]     r_mul_count;

    logic            w_adv_a;
    logic            w_adv_b;
    logic            w_grant_vld;
    logic [IDW-1:0]  w_grant;
    logic [IDW-1:0]  w_idx;
    logic            w_xfer;
    logic [NREQ-1:0] w_req_ready;
    logic [15:0]     w_mul_p;
    logic [15:0]     w_rsp_p_next;
    logic [9:0]      w_a [NREQ];
    logic [8:0]      w_b [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_a[g] = bus.req_a[10*g +: 10];
        assign w_b[g] = bus.req_b[9*g +: 9];
    end

    assign w_adv_b = !r_rsp_valid | bus.rsp_ready;
    assign w_adv_a = !r_op_vld | w_adv_b;

    // Scan from farthest to nearest so the requester closest to rr_ptr wins.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant     = '0;
        w_idx       = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = IDW'((int'(r_rr_ptr) + k) % NREQ);
            if (bus.req_valid[w_idx]) begin
                w_grant_vld = 1'b1;
                w_grant     = w_idx;
            end
        end
    end

    assign w_xfer = ap_rst_n & w_adv_a & w_grant_vld;

    always_comb begin
        w_req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_req_ready[i] = w_xfer & (w_grant == IDW'(i)) & bus.req_valid[i];
        end
    end

    fpga_top_mul_mul_10ns_9ns_16_1_1 u_mul (
        .i_din0 (r_op_a),
        .i_din1 (r_op_b),
        .o_dout (w_mul_p)
    );

`ifdef FPGA_TOP_MUL_ARB_SAT_EN
    logic [18:0] w_full;

    assign w_full       = {9'b0, r_op_a} * {10'b0, r_op_b};
    assign w_rsp_p_next = (w_full > 19'd65535) ? 16'hFFFF : w_mul_p;
`else
    assign w_rsp_p_next = w_mul_p;
`endif

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_op_vld <= 1'b0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_op_id  <= '0;
            r_rr_ptr <= '0;
        end else if (w_adv_a) begin
            r_op_vld <= w_grant_vld;
            r_op_a   <= w_a[w_grant];
            r_op_b   <= w_b[w_grant];
            r_op_id  <= w_grant;
            if (w_grant_vld) begin
                r_rr_ptr <= (w_grant == IDW'(NREQ - 1)) ? '0 : w_grant + 1'b1;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_p     <= '0;
            r_rsp_id    <= '0;
        end else if (w_adv_b) begin
            r_rsp_valid <= r_op_vld;
            r_rsp_p     <= w_rsp_p_next;
            r_rsp_id    <= r_op_id;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_mul_count <= '0;
        end else if (r_rsp_valid & bus.rsp_ready) begin
            r_mul_count <= r_mul_count + 32'd1;
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_p     = r_rsp_p;
    assign bus.mul_count = r_mul_count;
endmodule
